// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute-side request, Data_Memory port and writeback response bundle.
interface lsu_ctrl_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Store;
  logic [2:0]  Req_Funct3;
  logic [31:0] Req_Base;
  logic [31:0] Req_Offset;
  logic [31:0] Req_Data;
  logic [4:0]  Req_Rd;
  logic [31:0] Mem_Din;
  logic [31:0] Mem_WR_Addr;
  logic [31:0] Mem_RD_Addr;
  logic [1:0]  Mem_WE;
  logic [2:0]  Mem_RD_Type;
  logic [31:0] Mem_Dout;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [31:0] Rsp_Data;
  logic [4:0]  Rsp_Rd;
  logic        Rsp_Wb;
  logic [2:0]  Rsp_Exc;
  modport slave (
    input  Req_Valid, Req_Store, Req_Funct3, Req_Base, Req_Offset, Req_Data, Req_Rd,
    input  Mem_Dout, Rsp_Ready,
    output Req_Ready, Mem_Din, Mem_WR_Addr, Mem_RD_Addr, Mem_WE, Mem_RD_Type,
    output Rsp_Valid, Rsp_Data, Rsp_Rd, Rsp_Wb, Rsp_Exc
  );
  modport master (
    output Req_Valid, Req_Store, Req_Funct3, Req_Base, Req_Offset, Req_Data, Req_Rd,
    output Mem_Dout, Rsp_Ready,
    input  Req_Ready, Mem_Din, Mem_WR_Addr, Mem_RD_Addr, Mem_WE, Mem_RD_Type,
    input  Rsp_Valid, Rsp_Data, Rsp_Rd, Rsp_Wb, Rsp_Exc
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store stage; checks, drives Data_Memory, returns extended load data or exception.
module lsu_ctrl #(
  parameter int unsigned MEMORY_SIZE = 1024
) (
  input logic        Clk,
  input logic        Rst_n,
  lsu_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, STORE, LD_ISSUE, LD_CAPT, RESP} state_e;
  state_e      state_q;
  logic        ready_q, rsp_valid_q, rsp_wb_q;
  logic [1:0]  we_q, lane_q;
  logic [2:0]  f3_q, rsp_exc_q;
  logic [4:0]  rsp_rd_q;
  logic [31:0] din_q, wr_addr_q, rd_addr_q, rsp_data_q;
  logic [31:0] ea_d, ld_d;
  logic [32:0] end_d;
  logic [1:0]  we_d;
  logic [2:0]  exc_d;
  logic        illegal_d, misal_d, fault_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  always_comb begin
    ea_d      = bus.Req_Base + bus.Req_Offset;
    we_d      = bus.Req_Funct3[1:0] == 2'b00 ? 2'b01 : bus.Req_Funct3[1:0] == 2'b01 ? 2'b10 : 2'b11;
    // 33-bit end address so an EA near 2^32 faults instead of wrapping into range
    end_d     = {1'b0, ea_d} + (we_d == 2'b01 ? 33'd1 : we_d == 2'b10 ? 33'd2 : 33'd4);
    illegal_d = bus.Req_Store ? bus.Req_Funct3 > 3'b010
                              : (bus.Req_Funct3[1:0] == 2'b11 || bus.Req_Funct3 == 3'b110);
    misal_d   = (we_d == 2'b10 && ea_d[0]) || (we_d == 2'b11 && ea_d[1:0] != 2'b00);
    fault_d   = end_d > 33'(MEMORY_SIZE);
    exc_d     = illegal_d ? 3'b100 : misal_d ? (bus.Req_Store ? 3'b010 : 3'b001) : fault_d ? 3'b011 : 3'b000;
    byte_d    = 8'(bus.Mem_Dout >> {lane_q, 3'b000});
    half_d    = lane_q[1] ? bus.Mem_Dout[31:16] : bus.Mem_Dout[15:0];
    ld_d      = f3_q[1] ? bus.Mem_Dout
              : f3_q[0] ? {{16{~f3_q[2] & half_d[15]}}, half_d}
                        : {{24{~f3_q[2] & byte_d[7]}}, byte_d};
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      we_q        <= 2'b00;
      din_q       <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      lane_q      <= 2'b00;
      f3_q        <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_wb_q    <= 1'b0;
      rsp_exc_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: if (bus.Req_Valid) begin
          ready_q  <= 1'b0;
          rsp_rd_q <= bus.Req_Rd;
          lane_q   <= ea_d[1:0];
          f3_q     <= bus.Req_Funct3;
          if (exc_d != 3'b000) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_exc_q   <= exc_d;
            rsp_wb_q    <= 1'b0;
            rsp_data_q  <= '0;
          end else if (bus.Req_Store) begin
            state_q   <= STORE;
            we_q      <= we_d;
            wr_addr_q <= ea_d;
            din_q     <= bus.Req_Data;
          end else begin
            state_q   <= LD_ISSUE;
            rd_addr_q <= {ea_d[31:2], 2'b00};
          end
        end
        STORE: begin
          state_q     <= RESP;
          we_q        <= 2'b00;
          rsp_valid_q <= 1'b1;
          rsp_exc_q   <= 3'b000;
          rsp_wb_q    <= 1'b0;
          rsp_data_q  <= '0;
        end
        LD_ISSUE: state_q <= LD_CAPT;
        LD_CAPT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_exc_q   <= 3'b000;
          rsp_wb_q    <= 1'b1;
          rsp_data_q  <= ld_d;
        end
        RESP: if (bus.Rsp_Ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.Req_Ready   = ready_q;
  assign bus.Mem_Din     = din_q;
  assign bus.Mem_WR_Addr = wr_addr_q;
  assign bus.Mem_RD_Addr = rd_addr_q;
  assign bus.Mem_WE      = we_q;
  assign bus.Mem_RD_Type = 3'b010;
  assign bus.Rsp_Valid   = rsp_valid_q;
  assign bus.Rsp_Data    = rsp_data_q;
  assign bus.Rsp_Rd      = rsp_rd_q;
  assign bus.Rsp_Wb      = rsp_wb_q;
  assign bus.Rsp_Exc     = rsp_exc_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plan cases plus random ops against a byte-addressed reference model.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};
  logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [31:0] got_d;
  logic [2:0]  got_e;
  lsu_ctrl_if bus();
  lsu_ctrl #(.MEMORY_SIZE(1024)) dut (.Clk(clk), .Rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.Mem_WE != 2'b00) begin
      for (int i = 0; i < (bus.Mem_WE == 2'b01 ? 1 : bus.Mem_WE == 2'b10 ? 2 : 4); i++)
        mem[10'(bus.Mem_WR_Addr + 32'(i))] <= 8'(bus.Mem_Din >> (8 * i));
    end else begin
      bus.Mem_Dout <= {mem[10'(bus.Mem_RD_Addr + 32'd3)], mem[10'(bus.Mem_RD_Addr + 32'd2)],
                       mem[10'(bus.Mem_RD_Addr + 32'd1)], mem[10'(bus.Mem_RD_Addr)]};
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                                output logic [31:0] ea, output logic [2:0] exc, output int sz, output logic [31:0] ld);
    bit ill, mis;
    ea  = base + off;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (ea % sz) != 0;
    exc = ill ? 3'd4 : mis ? (st ? 3'd2 : 3'd1) : ({32'd0, ea} + 64'(sz) > 64'd1024) ? 3'd3 : 3'd0;
    ld  = 0;
    if (exc == 0 && !st) begin
      for (int i = 0; i < sz; i++) ld |= 32'(ref_mem[10'(ea + 32'(i))]) << (8 * i);
      if (!f3[2] && sz < 4 && ld[8 * sz - 1]) ld |= 32'hFFFFFFFF << (8 * sz);
    end
  endfunction
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] data, input logic [4:0] rd, input int bp,
                        output logic [31:0] rdata, output logic [2:0] rexc);
    logic [31:0] ea, exp_d, h_d;
    logic [2:0] exc, h_e;
    logic [4:0] h_rd;
    int sz, n, cyc, we_cnt;
    model(st, f3, base, off, ea, exc, sz, exp_d);
    @(negedge clk);
    bus.Req_Store = st; bus.Req_Funct3 = f3; bus.Req_Base = base; bus.Req_Offset = off;
    bus.Req_Data = data; bus.Req_Rd = rd; bus.Req_Valid = 1'b1; bus.Rsp_Ready = (bp == 0);
    n = 0;
    while (!bus.Req_Ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(bus.Req_Ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    cyc = 1; we_cnt = 0;
    while (!bus.Rsp_Valid && cyc < 8) begin
      check("busy_ready", 32'(bus.Req_Ready), 0);
      if (bus.Mem_WE != 2'b00) begin
        we_cnt++;
        check("mem_we", 32'(bus.Mem_WE), sz == 1 ? 1 : sz == 2 ? 2 : 3);
        check("wr_addr", bus.Mem_WR_Addr, ea);
        check("din", bus.Mem_Din, data);
      end
      if (cyc == 1 && !st && exc == 0) check("rd_addr", bus.Mem_RD_Addr, {ea[31:2], 2'b00});
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exc != 0 ? 1 : st ? 2 : 3);
    check("we_count", we_cnt, (exc == 0 && st) ? 1 : 0);
    check("we_idle_rsp", 32'(bus.Mem_WE), 0);
    check("rsp_exc", 32'(bus.Rsp_Exc), 32'(exc));
    check("rsp_wb", 32'(bus.Rsp_Wb), (exc == 0 && !st) ? 1 : 0);
    check("rsp_data", bus.Rsp_Data, exp_d);
    check("rsp_rd", 32'(bus.Rsp_Rd), 32'(rd));
    check("rd_type", 32'(bus.Mem_RD_Type), 2);
    rdata = bus.Rsp_Data; rexc = bus.Rsp_Exc;
    if (exc == 0 && st)
      for (int i = 0; i < sz; i++) ref_mem[10'(ea + 32'(i))] = 8'(data >> (8 * i));
    if (bp > 0) begin
      h_d = bus.Rsp_Data; h_e = bus.Rsp_Exc; h_rd = bus.Rsp_Rd;
      bus.Req_Valid = 1'b1;
      repeat (bp) begin
        @(negedge clk);
        check("bp_valid", 32'(bus.Rsp_Valid), 1);
        check("bp_data", bus.Rsp_Data, h_d);
        check("bp_exc", 32'(bus.Rsp_Exc), 32'(h_e));
        check("bp_rd", 32'(bus.Rsp_Rd), 32'(h_rd));
        check("bp_ready", 32'(bus.Req_Ready), 0);
      end
      bus.Req_Valid = 1'b0;
      bus.Rsp_Ready = 1'b1;
    end
    @(negedge clk);
    check("rsp_drop", 32'(bus.Rsp_Valid), 0);
    check("ready_back", 32'(bus.Req_Ready), 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.Req_Ready), 1);
    check({tag, "_we"}, 32'(bus.Mem_WE), 0);
    check({tag, "_din"}, bus.Mem_Din, 0);
    check({tag, "_wra"}, bus.Mem_WR_Addr, 0);
    check({tag, "_rda"}, bus.Mem_RD_Addr, 0);
    check({tag, "_valid"}, 32'(bus.Rsp_Valid), 0);
    check({tag, "_data"}, bus.Rsp_Data, 0);
    check({tag, "_rd"}, 32'(bus.Rsp_Rd), 0);
    check({tag, "_wb"}, 32'(bus.Rsp_Wb), 0);
    check({tag, "_exc"}, 32'(bus.Rsp_Exc), 0);
  endtask
  initial begin
    bus.Req_Valid = 1'b0; bus.Req_Store = 1'b0; bus.Req_Funct3 = 3'd0; bus.Req_Base = '0;
    bus.Req_Offset = '0; bus.Req_Data = '0; bus.Req_Rd = '0; bus.Rsp_Ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    run_op(1, 3'd2, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 0, got_d, got_e);
    check("sw_exc", 32'(got_e), 0);
    run_op(0, 3'd0, 32'h107, 32'h0, 32'h0, 5'd2, 0, got_d, got_e);
    check("lb_const", got_d, 32'hFFFFFFDE);
    run_op(0, 3'd4, 32'h104, 32'h0, 32'h0, 5'd3, 0, got_d, got_e);
    check("lbu_const", got_d, 32'h000000EF);
    run_op(0, 3'd5, 32'h106, 32'h0, 32'h0, 5'd4, 0, got_d, got_e);
    check("lhu_const", got_d, 32'h0000DEAD);
    run_op(0, 3'd1, 32'h104, 32'h0, 32'h0, 5'd5, 0, got_d, got_e);
    check("lh_const", got_d, 32'hFFFFBEEF);
    run_op(0, 3'd2, 32'h102, 32'h0, 32'h0, 5'd6, 0, got_d, got_e);
    check("lw_mis_const", 32'(got_e), 1);
    run_op(1, 3'd1, 32'h3FF, 32'h0, 32'h1234, 5'd7, 0, got_d, got_e);
    check("sh_mis_const", 32'(got_e), 2);
    run_op(1, 3'd2, 32'h3FE, 32'h0, 32'h1234, 5'd8, 0, got_d, got_e);
    check("sw_mis_const", 32'(got_e), 2);
    run_op(1, 3'd0, 32'h400, 32'h0, 32'h55, 5'd9, 0, got_d, got_e);
    check("sb_fault_const", 32'(got_e), 3);
    run_op(0, 3'd3, 32'h100, 32'h0, 32'h0, 5'd10, 0, got_d, got_e);
    check("ill_const", 32'(got_e), 4);
    run_op(0, 3'd2, 32'h10, 32'hFFFFFFF0, 32'h0, 5'd11, 0, got_d, got_e);
    check("neg_off_exc", 32'(got_e), 0);
    run_op(0, 3'd2, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd12, 0, got_d, got_e);
    check("wrap_fault", 32'(got_e), 3);
    run_op(0, 3'd2, 32'h104, 32'h0, 32'h0, 5'd13, 5, got_d, got_e);
    check("bp_lw_const", got_d, 32'hDEADBEEF);
    @(negedge clk);
    bus.Req_Store = 1'b0; bus.Req_Funct3 = 3'd2; bus.Req_Base = 32'h104; bus.Req_Offset = '0;
    bus.Req_Rd = 5'd14; bus.Req_Valid = 1'b1; bus.Rsp_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_still_idle", 32'(bus.Rsp_Valid), 0);
    run_op(0, 3'd2, 32'h104, 32'h0, 32'h0, 5'd15, 0, got_d, got_e);
    check("post_rst_lw", got_d, 32'hDEADBEEF);
    for (int k = 0; k < 300; k++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] base, off;
      int bp;
      st   = 1'($urandom_range(0, 1));
      f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      base = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(32'h380, 32'h3FF));
      off  = 32'($urandom_range(0, 40)) - 32'd20;
      bp   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(st, f3, base, off, $urandom, 5'($urandom), bp, got_d, got_e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
